// File: rtl/data_nway_writeback_cache_controller.sv
// Control FSM for an N-way write-back data cache with a word-serial bus.
// Holds only FSM state, the bus beat counter and the latched victim way.
module data_nway_writeback_cache_controller #(
  parameter int NUM_WAYS          = 4,
  parameter int WORDS_PER_BLOCK   = 4,
  parameter bit ALLOCATE_ON_WRITE = 1'b1,
  localparam int WAYW = $clog2(NUM_WAYS),
  localparam int OFFW = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                IStall,
  input  logic                MemWriteM,
  input  logic                MemtoRegM,
  input  logic                BusReady,
  input  logic [OFFW-1:0]     WordOffset,
  input  logic [NUM_WAYS-1:0] WayValid,
  input  logic [NUM_WAYS-1:0] WayHit,
  input  logic [NUM_WAYS-1:0] WayDirty,
  input  logic [WAYW-1:0]     ReplWay,
  output logic                Stall,
  output logic                CWE,
  output logic [NUM_WAYS-1:0] WayWE,
  output logic [WAYW-1:0]     SelWay,
  output logic                BlockWE,
  output logic                HRequestM,
  output logic                HWriteM,
  output logic                WriteThru,
  output logic                RDSel,
  output logic [OFFW-1:0]     Counter,
  output logic [OFFW-1:0]     CacheRDSel,
  output logic                LRUUpdate
);

  localparam logic [2:0] READY     = 3'd0;
  localparam logic [2:0] WRITEBACK = 3'd1;
  localparam logic [2:0] MEMREAD   = 3'd2;
  localparam logic [2:0] WRITETHRU = 3'd3;
  localparam logic [2:0] NEXTINSTR = 3'd4;
  localparam logic [2:0] WAIT      = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [OFFW-1:0] counter_q, counter_d;
  logic [WAYW-1:0] victim_q, victim_d;
  logic [WAYW-1:0] comb_way;
  logic            hit, access, dirty, last_beat;
  logic            st_ready, st_wb, st_mr, st_wt, st_ni;

  assign hit       = |WayHit;
  assign access    = MemWriteM | MemtoRegM;
  assign last_beat = (counter_q == OFFW'(WORDS_PER_BLOCK - 1));

  assign st_ready = (state_q == READY);
  assign st_wb    = (state_q == WRITEBACK);
  assign st_mr    = (state_q == MEMREAD);
  assign st_wt    = (state_q == WRITETHRU);
  assign st_ni    = (state_q == NEXTINSTR);

  // Scan from the top so the lowest-index match wins; hits override invalid ways.
  always_comb begin
    comb_way = ReplWay;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!WayValid[i]) comb_way = WAYW'(i);
    end
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (WayHit[i]) comb_way = WAYW'(i);
    end
  end

  assign SelWay = st_ready ? comb_way : victim_q;
  assign dirty  = WayValid[SelWay] & WayDirty[SelWay];

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    victim_d  = victim_q;
    case (state_q)
      READY: begin
        counter_d = '0;
        if (access && !hit) begin
          victim_d = comb_way;
          if (MemWriteM && !ALLOCATE_ON_WRITE) state_d = WRITETHRU;
          else if (dirty)                      state_d = WRITEBACK;
          else                                 state_d = MEMREAD;
        end
      end
      WRITEBACK: begin
        if (BusReady) begin
          counter_d = counter_q + OFFW'(1);
          if (last_beat) state_d = MEMREAD;
        end
      end
      MEMREAD: begin
        if (BusReady) begin
          counter_d = counter_q + OFFW'(1);
          if (last_beat) state_d = NEXTINSTR;
        end
      end
      WRITETHRU: begin
        if (BusReady) state_d = NEXTINSTR;
      end
      NEXTINSTR, WAIT: begin
        counter_d = '0;
        state_d   = IStall ? WAIT : READY;
      end
      default: begin
        counter_d = '0;
        state_d   = READY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= READY;
      counter_q <= '0;
      victim_q  <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      victim_q  <= victim_d;
    end
  end

  assign Stall      = st_wb | st_mr | st_wt | (st_ready & access & ~hit);
  assign CWE        = (st_ready & MemWriteM & hit) | (st_mr & BusReady);
  assign BlockWE    = st_mr;
  assign HRequestM  = st_wb | st_mr | st_wt;
  assign HWriteM    = st_wb | st_wt;
  assign WriteThru  = st_wt;
  assign Counter    = counter_q;
  assign CacheRDSel = st_wb ? counter_q : WordOffset;
  assign RDSel      = st_ni & (WordOffset == OFFW'(WORDS_PER_BLOCK - 1));
  assign LRUUpdate  = (st_ready & access & hit) | (st_mr & BusReady & last_beat);

  always_comb begin
    WayWE         = '0;
    WayWE[SelWay] = CWE;
  end

endmodule

// File: tb/tb_data_nway_writeback_cache_controller.sv
// Scoreboard bench: stimulus queues expected output vectors, a negedge monitor compares.
module tb_data_nway_writeback_cache_controller;

  logic       clk = 1'b0;
  logic       rst_n, istall, memw, memr, busr;
  logic [1:0] woff, repl;
  logic [3:0] wvalid, whit, wdirty;

  logic       a_stall, a_cwe, a_bwe, a_hreq, a_hw, a_wt, a_rds, a_lru;
  logic [3:0] a_wwe;
  logic [1:0] a_sel, a_cnt, a_crd;
  logic       b_stall, b_cwe, b_bwe, b_hreq, b_hw, b_wt, b_rds, b_lru;
  logic [3:0] b_wwe;
  logic [1:0] b_sel, b_cnt, b_crd;

  always #5 clk = ~clk;

  data_nway_writeback_cache_controller #(.NUM_WAYS(4), .WORDS_PER_BLOCK(4), .ALLOCATE_ON_WRITE(1'b1)) u_a (
    .clk(clk), .reset(rst_n), .IStall(istall), .MemWriteM(memw), .MemtoRegM(memr),
    .BusReady(busr), .WordOffset(woff), .WayValid(wvalid), .WayHit(whit), .WayDirty(wdirty),
    .ReplWay(repl), .Stall(a_stall), .CWE(a_cwe), .WayWE(a_wwe), .SelWay(a_sel),
    .BlockWE(a_bwe), .HRequestM(a_hreq), .HWriteM(a_hw), .WriteThru(a_wt), .RDSel(a_rds),
    .Counter(a_cnt), .CacheRDSel(a_crd), .LRUUpdate(a_lru));

  data_nway_writeback_cache_controller #(.NUM_WAYS(4), .WORDS_PER_BLOCK(4), .ALLOCATE_ON_WRITE(1'b0)) u_b (
    .clk(clk), .reset(rst_n), .IStall(istall), .MemWriteM(memw), .MemtoRegM(memr),
    .BusReady(busr), .WordOffset(woff), .WayValid(wvalid), .WayHit(whit), .WayDirty(wdirty),
    .ReplWay(repl), .Stall(b_stall), .CWE(b_cwe), .WayWE(b_wwe), .SelWay(b_sel),
    .BlockWE(b_bwe), .HRequestM(b_hreq), .HWriteM(b_hw), .WriteThru(b_wt), .RDSel(b_rds),
    .Counter(b_cnt), .CacheRDSel(b_crd), .LRUUpdate(b_lru));

  // Vector layout: stall cwe wwe[3:0] sel[1:0] bwe hreq hw wt rds cnt[1:0] crd[1:0] lru
  logic [17:0] act_a, act_b;
  assign act_a = {a_stall, a_cwe, a_wwe, a_sel, a_bwe, a_hreq, a_hw, a_wt, a_rds, a_cnt, a_crd, a_lru};
  assign act_b = {b_stall, b_cwe, b_wwe, b_sel, b_bwe, b_hreq, b_hw, b_wt, b_rds, b_cnt, b_crd, b_lru};

  logic [17:0] exp_q[$];
  string       name_q[$];
  bit          dut_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [17:0] mk(int st, int cw, int ww, int sl, int bw, int hq,
                                     int hw, int wt, int rd, int cn, int cr, int lr);
    return {1'(st), 1'(cw), 4'(ww), 2'(sl), 1'(bw), 1'(hq), 1'(hw), 1'(wt), 1'(rd),
            2'(cn), 2'(cr), 1'(lr)};
  endfunction

  // Inputs for the current cycle are already applied; queue the expectation and advance.
  task automatic chk(input string nm, input bit which, input logic [17:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    dut_q.push_back(which);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; istall = 1'b0; memw = 1'b0; memr = 1'b0; busr = 1'b0;
    woff = 2'd0; repl = 2'd0; wvalid = 4'b0000; whit = 4'b0000; wdirty = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [17:0] e, got;
      string nm;
      bit which;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      which = dut_q.pop_front();
      got = which ? act_b : act_a;
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s (dut %0d): got %b required %b", nm, which, got, e);
      end
    end
  end

  initial begin
    do_reset();

    // Reset state: idle READY, SelWay follows CombWay (all valid -> ReplWay).
    wvalid = 4'b1111; repl = 2'd2;
    chk("reset_a", 0, mk(0,0,0,2,0,0,0,0,0,0,0,0));
    chk("reset_b", 1, mk(0,0,0,2,0,0,0,0,0,0,0,0));

    // Hits: zero latency, LRU pulse, lowest hitting way wins.
    memr = 1'b1; whit = 4'b0100; woff = 2'd1;
    chk("load_hit", 0, mk(0,0,0,2,0,0,0,0,0,0,1,1));
    memr = 1'b0;
    chk("hit_idle", 0, mk(0,0,0,2,0,0,0,0,0,0,1,0));
    memw = 1'b1; whit = 4'b0110;
    chk("store_multi_hit", 0, mk(0,1,4'b0010,1,0,0,0,0,0,0,1,1));

    // Clean load miss into the first invalid way (way 1).
    do_reset();
    memr = 1'b1; wvalid = 4'b1101; woff = 2'd3;
    chk("lmiss_ready", 0, mk(1,0,0,1,0,0,0,0,0,0,3,0));
    busr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) wvalid = 4'b1111;
      chk("lmiss_fill", 0, mk(1,1,4'b0010,1,1,1,0,0,0,k,3,(k == 3)));
    end
    busr = 1'b0;
    chk("lmiss_nextinstr", 0, mk(0,0,0,1,0,0,0,0,1,0,3,0));
    whit = 4'b0010;
    chk("lmiss_rehit", 0, mk(0,0,0,1,0,0,0,0,0,0,3,1));

    // Dirty store miss: writeback, fill, then the store hits.
    do_reset();
    memw = 1'b1; wvalid = 4'b1111; repl = 2'd3; wdirty = 4'b1000; woff = 2'd2;
    chk("smiss_ready", 0, mk(1,0,0,3,0,0,0,0,0,0,2,0));
    busr = 1'b1;
    for (int k = 0; k < 4; k++)
      chk("smiss_wb", 0, mk(1,0,0,3,0,1,1,0,0,k,k,0));
    for (int k = 0; k < 4; k++) begin
      if (k == 1) repl = 2'd0;
      chk("smiss_fill", 0, mk(1,1,4'b1000,3,1,1,0,0,0,k,2,(k == 3)));
    end
    busr = 1'b0;
    chk("smiss_nextinstr", 0, mk(0,0,0,3,0,0,0,0,0,0,2,0));
    whit = 4'b1000;
    chk("smiss_store", 0, mk(0,1,4'b1000,3,0,0,0,0,0,0,2,1));

    // Fill with BusReady gaps, then IStall holds two WAIT cycles.
    do_reset();
    memr = 1'b1; wvalid = 4'b1111; repl = 2'd0; woff = 2'd3;
    chk("gap_ready", 0, mk(1,0,0,0,0,0,0,0,0,0,3,0));
    busr = 1'b1; chk("gap_b1", 0, mk(1,1,4'b0001,0,1,1,0,0,0,0,3,0));
    busr = 1'b0; chk("gap_b2", 0, mk(1,0,0,0,1,1,0,0,0,1,3,0));
    busr = 1'b0; chk("gap_b3", 0, mk(1,0,0,0,1,1,0,0,0,1,3,0));
    busr = 1'b1; chk("gap_b4", 0, mk(1,1,4'b0001,0,1,1,0,0,0,1,3,0));
    busr = 1'b1; chk("gap_b5", 0, mk(1,1,4'b0001,0,1,1,0,0,0,2,3,0));
    busr = 1'b0; chk("gap_b6", 0, mk(1,0,0,0,1,1,0,0,0,3,3,0));
    busr = 1'b1; chk("gap_b7", 0, mk(1,1,4'b0001,0,1,1,0,0,0,3,3,1));
    busr = 1'b0; istall = 1'b1;
    chk("gap_nextinstr", 0, mk(0,0,0,0,0,0,0,0,1,0,3,0));
    chk("gap_wait1", 0, mk(0,0,0,0,0,0,0,0,0,0,3,0));
    istall = 1'b0;
    chk("gap_wait2", 0, mk(0,0,0,0,0,0,0,0,0,0,3,0));
    whit = 4'b0001;
    chk("gap_ready_hit", 0, mk(0,0,0,0,0,0,0,0,0,0,3,1));

    // Reset in the middle of a writeback.
    do_reset();
    memw = 1'b1; wvalid = 4'b1111; repl = 2'd1; wdirty = 4'b0010;
    chk("rstwb_ready", 0, mk(1,0,0,1,0,0,0,0,0,0,0,0));
    busr = 1'b1;
    chk("rstwb_b0", 0, mk(1,0,0,1,0,1,1,0,0,0,0,0));
    chk("rstwb_b1", 0, mk(1,0,0,1,0,1,1,0,0,1,1,0));
    busr = 1'b0; rst_n = 1'b0;
    chk("rstwb_cnt2", 0, mk(1,0,0,1,0,1,1,0,0,2,2,0));
    rst_n = 1'b1;
    chk("rstwb_after", 0, mk(1,0,0,1,0,0,0,0,0,0,0,0));

    // No-allocate store miss: single write-through beat, dirty victim ignored.
    do_reset();
    memw = 1'b1; wvalid = 4'b1111; repl = 2'd2; wdirty = 4'b0100; woff = 2'd3;
    chk("wt_ready", 1, mk(1,0,0,2,0,0,0,0,0,0,3,0));
    chk("wt_wait1", 1, mk(1,0,0,2,0,1,1,1,0,0,3,0));
    chk("wt_wait2", 1, mk(1,0,0,2,0,1,1,1,0,0,3,0));
    busr = 1'b1;
    chk("wt_beat", 1, mk(1,0,0,2,0,1,1,1,0,0,3,0));
    busr = 1'b0; memw = 1'b0;
    chk("wt_nextinstr", 1, mk(0,0,0,2,0,0,0,0,1,0,3,0));
    chk("wt_ready_idle", 1, mk(0,0,0,2,0,0,0,0,0,0,3,0));

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_nway_writeback_cache_controller.md
# data_nway_writeback_cache_controller

Control FSM for the data-side write-back cache, generalised to NUM_WAYS-way set associativity and WORDS_PER_BLOCK-word blocks. It adds a selectable write-miss policy (write-allocate or no-allocate write-through) and latches the victim way for the duration of a miss. It sits between the memory-stage pipeline signals, the per-way tag/valid/dirty arrays, an external replacement store, and the word-serial bus. It holds no data or tag storage itself.

## Interface
- NUM_WAYS, 4: ways per set; power of two, 2..8. WAYW = log2(NUM_WAYS).
- WORDS_PER_BLOCK, 4: words per block; power of two, 2..16. OFFW = log2(WORDS_PER_BLOCK).
- ALLOCATE_ON_WRITE, 1: on a store miss, 1 = fill the block then write it; 0 = single-word write-through, no fill.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk.
- IStall  in  1  instruction side is stalling.
- MemWriteM, MemtoRegM  in  1 each  store / load in the memory stage.
- BusReady  in  1  bus accepted or delivered one word this cycle.
- WordOffset  in  OFFW  word offset of the access.
- WayValid, WayHit, WayDirty  in  NUM_WAYS each  per-way valid, tag-hit and dirty for the indexed set.
- ReplWay  in  WAYW  victim proposed by the external replacement store.
- Stall  out  1  freeze the pipeline.
- CWE  out  1  cache word write enable.
- WayWE  out  NUM_WAYS  one-hot, equal to CWE gated to SelWay.
- SelWay  out  WAYW  way used for readout, write, writeback and fill.
- BlockWE  out  1  write tag, set valid and set dirty-per-policy on the selected way.
- HRequestM, HWriteM  out  1 each  bus request / bus write.
- WriteThru  out  1  bus write data comes from the store data, not the cache.
- RDSel  out  1  select bus data for the load result.
- Counter  out  OFFW  bus beat counter.
- CacheRDSel  out  OFFW  cache word read select.
- LRUUpdate  out  1  one-cycle pulse: mark SelWay most-recently-used.

## Operation
- Hit = OR(WayHit). Access = MemWriteM | MemtoRegM.
- Combinational way choice, CombWay:
  - On a hit, the lowest-index hitting way.
  - Otherwise, the lowest-index way with WayValid = 0.
  - Otherwise, ReplWay.
- VictimWay register:
  - Loaded with CombWay on the edge that leaves READY on a miss.
  - Held in every state other than READY.
- SelWay = CombWay in READY, otherwise VictimWay.
- Dirty = WayValid[SelWay] & WayDirty[SelWay].
- States: READY, WRITEBACK, MEMREAD, WRITETHRU, NEXTINSTR, WAIT.
- READY transitions:
  - Stays in READY if Hit or ~Access.
  - Store miss with ALLOCATE_ON_WRITE = 0 goes to WRITETHRU.
  - Other misses: Dirty goes to WRITEBACK, ~Dirty goes to MEMREAD.
- Bus and exit transitions:
  - WRITEBACK goes to MEMREAD when BusReady & Counter == WORDS_PER_BLOCK-1.
  - MEMREAD goes to NEXTINSTR when BusReady & Counter == WORDS_PER_BLOCK-1.
  - WRITETHRU goes to NEXTINSTR on BusReady.
  - NEXTINSTR and WAIT go to WAIT if IStall, otherwise to READY.
- Counter:
  - Cleared in READY, NEXTINSTR and WAIT.
  - Increments on BusReady in WRITEBACK and MEMREAD, wrapping modulo WORDS_PER_BLOCK.
  - Holds otherwise.
- Outputs:
  - Stall = WRITEBACK | MEMREAD | WRITETHRU | (READY & Access & ~Hit).
  - CWE = (READY & MemWriteM & Hit) | (MEMREAD & BusReady).
  - BlockWE = MEMREAD.
  - HRequestM = WRITEBACK | MEMREAD | WRITETHRU.
  - HWriteM = WRITEBACK | WRITETHRU.
  - WriteThru = WRITETHRU.
  - CacheRDSel = Counter in WRITEBACK, otherwise WordOffset.
  - RDSel = NEXTINSTR & WordOffset == WORDS_PER_BLOCK-1.
  - LRUUpdate = (READY & Access & Hit) | (MEMREAD & BusReady & Counter == WORDS_PER_BLOCK-1).
- A store miss with allocate completes through the fill: after NEXTINSTR it returns to READY, now hits, and CWE writes the store word.
- Multiple WayHit bits set is illegal; the lowest-index hit wins, with no error flag.

## Timing
- Reset (reset = 0 at an edge):
  - Next state READY, Counter = 0, VictimWay = 0.
  - This overrides any in-flight bus transfer; the bus side must drop the transfer when HRequestM falls.
- Reset output values (given WayHit = 0 and Access = 0): all single-bit outputs 0, WayWE = 0, Counter = 0, SelWay = CombWay.
- Hit latency: 0 extra cycles. The store write, or the load read from the cache word, happens in the same cycle.
- Clean miss: minimum WORDS_PER_BLOCK + 1 stall cycles (one per fill beat, plus the cycle in READY), then NEXTINSTR.
- Dirty miss: adds WORDS_PER_BLOCK writeback beats.
- BusReady low inserts wait cycles; Counter and state hold.
- BusReady in READY, NEXTINSTR or WAIT is ignored.
- IStall in NEXTINSTR adds WAIT cycles until IStall = 0.
- Invalid ways and WayHit changing during a fill do not alter SelWay, because SelWay comes from the latched VictimWay.

## Test plan
- NUM_WAYS=4, WORDS=4, load with WayHit=0100 → Stall=0, SelWay=2, LRUUpdate=1 for 1 cycle, HRequestM=0.
- Load miss, WayValid=1101, all clean → MEMREAD. 4 BusReady beats give CWE=1 and WayWE=0010 on each beat, Counter 0→3. Then NEXTINSTR and READY; LRUUpdate on the 4th beat.
- Store miss, all valid, ReplWay=3, WayDirty[3]=1 → 4 WRITEBACK beats (HWriteM=1, CacheRDSel=0..3), then 4 MEMREAD beats with WayWE=1000. ReplWay changes mid-fill but SelWay stays 3. Back in READY with a hit: CWE=1.
- ALLOCATE_ON_WRITE=0, store miss, BusReady after 3 cycles → WRITETHRU with HRequestM=HWriteM=WriteThru=1 for 3 cycles. WayWE=0 and BlockWE=0 throughout. Then NEXTINSTR.
- Fill with BusReady gaps (pattern 1,0,0,1,1,0,1) and IStall=1 for 2 cycles in NEXTINSTR → Counter holds during gaps; exactly 2 WAIT cycles, then READY.
- reset=0 during WRITEBACK with Counter=2 → next cycle READY, Counter=0, HRequestM=0, Stall follows the READY rule.
